bus_grant_encoder: RTL and testbench
====================================

Name: bus_grant_encoder

Overview:
- Bus-side initiator/arbiter for the 8-module shared bus.
- Collects one-hot request lines from the 8 modules and picks one owner round-robin.
- Encodes that owner into a 3-bit address, which drives the existing address decoder's ADDR input.
- Holds the grant until the owner signals DONE, drops its request, or a watchdog timeout fires.

Parameters:
- N_MOD, 8, number of requesters; fixed to 8 in this revision.
- ADDR_W, 3, width of the encoded address; equals clog2(N_MOD).
- TIMEOUT_CYCLES, 256, maximum cycles a grant may be held; 0 disables the watchdog.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST_N  input  1  asynchronous active-low reset.
- REQ  input  8  per-module request, level; bit i = module i.
- DONE  input  1  current owner finished; sampled only while GRANT_VALID=1.
- GRANT_VALID  output  1  a grant is active.
- GRANT_ADDR  output  3  encoded owner address; drives the decoder ADDR.
- GRANT_ONEHOT  output  8  registered one-hot of the owner; all zeros when GRANT_VALID=0.
- TIMEOUT  output  1  one-cycle pulse when a grant is revoked by the watchdog.
- TIMEOUT_ADDR  output  3  address of the revoked owner; held until the next timeout.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - State IDLE.
  - GRANT_VALID=0, GRANT_ADDR=0, GRANT_ONEHOT=0, TIMEOUT=0, TIMEOUT_ADDR=0.
  - Priority pointer PTR=0, watchdog counter=0.
- All outputs are registered. No combinational path exists from REQ or DONE to any output.
- FSM states: IDLE, GRANT.
- IDLE:
  - If REQ≠0, select the first set bit searching PTR, PTR+1, … wrapping mod 8.
  - At the next edge: go to GRANT, GRANT_VALID=1, GRANT_ADDR=sel, GRANT_ONEHOT=1<<sel, PTR=(sel+1) mod 8 (3-bit natural wrap), counter=0.
  - If REQ=0, stay in IDLE.
- Latency: REQ sampled high at edge k gives GRANT_VALID=1 after edge k (visible in cycle k+1).
- GRANT, release conditions, evaluated each edge in this order:
  - (a) DONE=1 → release.
  - (b) REQ[GRANT_ADDR]=0 → release (abort, no TIMEOUT).
  - (c) TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1 → release, TIMEOUT=1 for exactly one cycle, TIMEOUT_ADDR=GRANT_ADDR.
  - Otherwise counter increments.
- Release:
  - Return to IDLE; GRANT_VALID=0, GRANT_ONEHOT=0.
  - GRANT_ADDR holds its last value; consumers must qualify it with GRANT_VALID.
- Turnaround: at least one IDLE cycle always separates consecutive grants, even to a different module.
- Simultaneous DONE and timeout on the same edge: DONE wins, no TIMEOUT pulse.
- DONE while in IDLE: ignored.
- REQ changes while in GRANT: non-owner bits are ignored until the next IDLE.
- Re-grant to the same module right after release happens only when no other module requests (round-robin fairness).
- Counter width: max(1, clog2(TIMEOUT_CYCLES)). The counter saturates and is never compared when TIMEOUT_CYCLES=0.
- Reset mid-grant: immediate return to the reset values, including PTR=0; no TIMEOUT pulse.

Decomposition:
- Package bus_pkg holds:
  - N_MOD=8 and ADDR_W=3 constants.
  - The state typedef {IDLE, GRANT}.
  - The one-hot/encode helper function shared with the address decoder.
- One combinational sub-module, rr_priority_select:
  - Inputs: REQ[7:0] and PTR[2:0].
  - Outputs: sel[2:0] and any_req.
  - Implemented as a rotate / priority-encode / un-rotate.
- FSM, counter and output registers live in bus_grant_encoder.

Test Plan:
1. Reset then REQ=8'h04 → one cycle later GRANT_VALID=1, GRANT_ADDR=2, GRANT_ONEHOT=8'h04; pulse DONE → GRANT_VALID=0 next cycle, PTR=3.
2. REQ=8'hFF held, DONE pulsed on every grant's first cycle → GRANT_ADDR sequence 0,1,2,3,4,5,6,7,0, each grant separated by exactly one IDLE cycle.
3. TIMEOUT_CYCLES=16, REQ=8'h80, DONE never → GRANT_VALID high for exactly 16 cycles, then TIMEOUT=1 for one cycle with TIMEOUT_ADDR=7; re-grant to 7 after one IDLE cycle.
4. TIMEOUT_CYCLES=16, DONE asserted on the 16th grant cycle → release with TIMEOUT=0 and TIMEOUT_ADDR unchanged.
5. Owner 5 granted (REQ=8'h21, PTR=1) → owner drops REQ[5] → release next edge with no TIMEOUT; next grant goes to 0.
6. RST_N low during a grant to 3 → outputs zero asynchronously; after release REQ=8'h09 → GRANT_ADDR=0 (PTR reset to 0).

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the 8-module shared bus: sizes, arbiter state
// encoding and the address-to-one-hot helper also used by the address decoder.
package bus_pkg;

    localparam int unsigned N_MOD  = 8;
    localparam int unsigned ADDR_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // One-hot select line for a module address.
    function automatic logic [N_MOD-1:0] addr_to_onehot(input logic [ADDR_W-1:0] addr);
        return N_MOD'(1) << addr;
    endfunction

endpackage : bus_pkg

// File: rtl/rr_priority_select.sv
// Round-robin priority selector (purely combinational).
//   req     : per-module request vector, bit i = module i
//   ptr     : highest-priority module for this search
//   sel     : first requesting module found searching ptr, ptr+1, ... mod N_MOD
//   any_req : at least one request is present (sel is don't-care otherwise)
module rr_priority_select
    import bus_pkg::*;
(
    input  logic [N_MOD-1:0]  req,
    input  logic [ADDR_W-1:0] ptr,
    output logic [ADDR_W-1:0] sel,
    output logic              any_req
);

    logic [N_MOD-1:0]  rot;
    logic [ADDR_W-1:0] idx;

    // Rotate so ptr lands on bit 0, find the lowest set bit, rotate back.
    always_comb begin
        rot = N_MOD'({req, req} >> ptr);
        idx = '0;
        for (int i = N_MOD - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = ADDR_W'(i);
            end
        end
        sel     = idx + ptr;
        any_req = |req;
    end

endmodule : rr_priority_select

// File: rtl/bus_grant_encoder.sv
// Round-robin bus arbiter for the 8-module shared bus. Grants one owner,
// encodes it onto the decoder address, and holds the grant until DONE,
// the owner drops its request, or the watchdog expires.
//   clk, rst_n    : clock, asynchronous active-low reset
//   req           : per-module level requests
//   done          : owner finished (only looked at while granted)
//   grant_valid   : a grant is active
//   grant_addr    : owner address; holds its last value after release
//   grant_onehot  : one-hot owner, zero when no grant
//   timeout       : one-cycle pulse when the watchdog revokes a grant
//   timeout_addr  : owner revoked by the most recent timeout
module bus_grant_encoder
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_MOD-1:0]  req,
    input  logic              done,
    output logic              grant_valid,
    output logic [ADDR_W-1:0] grant_addr,
    output logic [N_MOD-1:0]  grant_onehot,
    output logic              timeout,
    output logic [ADDR_W-1:0] timeout_addr
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          WDOG_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t            state, state_d;
    logic [ADDR_W-1:0] ptr, ptr_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              grant_valid_d;
    logic [ADDR_W-1:0] grant_addr_d;
    logic [N_MOD-1:0]  grant_onehot_d;
    logic              timeout_d;
    logic [ADDR_W-1:0] timeout_addr_d;

    logic [ADDR_W-1:0] sel;
    logic              any_req;

    rr_priority_select u_sel (
        .req     (req),
        .ptr     (ptr),
        .sel     (sel),
        .any_req (any_req)
    );

    // Next state and next output values.
    always_comb begin
        state_d        = state;
        ptr_d          = ptr;
        cnt_d          = cnt;
        grant_valid_d  = grant_valid;
        grant_addr_d   = grant_addr;
        grant_onehot_d = grant_onehot;
        timeout_d      = 1'b0;
        timeout_addr_d = timeout_addr;

        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_d        = GRANT;
                    grant_valid_d  = 1'b1;
                    grant_addr_d   = sel;
                    grant_onehot_d = addr_to_onehot(sel);
                    ptr_d          = sel + ADDR_W'(1);
                    cnt_d          = '0;
                end
            end
            GRANT: begin
                // Release priority: DONE, then owner abort, then watchdog.
                if (done || !req[grant_addr]) begin
                    state_d        = IDLE;
                    grant_valid_d  = 1'b0;
                    grant_onehot_d = '0;
                end else if (WDOG_EN && (cnt == CNT_LAST)) begin
                    state_d        = IDLE;
                    grant_valid_d  = 1'b0;
                    grant_onehot_d = '0;
                    timeout_d      = 1'b1;
                    timeout_addr_d = grant_addr;
                end else if (cnt != '1) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            grant_valid  <= 1'b0;
            grant_addr   <= '0;
            grant_onehot <= '0;
            timeout      <= 1'b0;
            timeout_addr <= '0;
        end else begin
            state        <= state_d;
            ptr          <= ptr_d;
            cnt          <= cnt_d;
            grant_valid  <= grant_valid_d;
            grant_addr   <= grant_addr_d;
            grant_onehot <= grant_onehot_d;
            timeout      <= timeout_d;
            timeout_addr <= timeout_addr_d;
        end
    end

endmodule : bus_grant_encoder

// File: tb/tb_bus_grant_encoder.sv
// Self-checking bench for bus_grant_encoder (watchdog set to 16 cycles).
module tb_bus_grant_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       grant_valid;
    logic [2:0] grant_addr;
    logic [7:0] grant_onehot;
    logic       timeout;
    logic [2:0] timeout_addr;

    typedef struct {
        logic       v;
        logic [2:0] a;
        logic [7:0] oh;
        logic       to;
        logic [2:0] ta;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_cyc    = 0;

    bus_grant_encoder #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .done         (done),
        .grant_valid  (grant_valid),
        .grant_addr   (grant_addr),
        .grant_onehot (grant_onehot),
        .timeout      (timeout),
        .timeout_addr (timeout_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic exp_t mk(input logic v, input logic [2:0] a, input logic [7:0] oh,
                                input logic to, input logic [2:0] ta);
        exp_t e;
        e.v = v; e.a = a; e.oh = oh; e.to = to; e.ta = ta;
        return e;
    endfunction

    function automatic logic [7:0] oh_of(input int a);
        logic [7:0] one;
        one = 8'h01;
        return one << a;
    endfunction

    // Drive one cycle of stimulus, push its expected result, compare after the edge.
    task automatic cyc(input logic [7:0] r, input logic d, input exp_t e);
        exp_t got;
        @(negedge clk);
        req  = r;
        done = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_cyc++;
        got = sb.pop_front();
        check($sformatf("c%0d valid", n_cyc), 32'(grant_valid), 32'(got.v));
        check($sformatf("c%0d addr", n_cyc), 32'(grant_addr), 32'(got.a));
        check($sformatf("c%0d onehot", n_cyc), 32'(grant_onehot), 32'(got.oh));
        check($sformatf("c%0d timeout", n_cyc), 32'(timeout), 32'(got.to));
        check($sformatf("c%0d to_addr", n_cyc), 32'(timeout_addr), 32'(got.ta));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " valid"}, 32'(grant_valid), 32'd0);
        check({tag, " addr"}, 32'(grant_addr), 32'd0);
        check({tag, " onehot"}, 32'(grant_onehot), 32'd0);
        check({tag, " timeout"}, 32'(timeout), 32'd0);
        check({tag, " to_addr"}, 32'(timeout_addr), 32'd0);
    endtask

    initial begin
        int a;
        int prev;
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, released by DONE; pointer moves to 3.
        cyc(8'h04, 1'b0, mk(1, 2, 8'h04, 0, 0));
        cyc(8'h04, 1'b1, mk(0, 2, 8'h00, 0, 0));
        cyc(8'hFF, 1'b0, mk(1, 3, 8'h08, 0, 0));

        // All requesting, DONE on each grant's first cycle: one IDLE between grants.
        prev = 3;
        for (int i = 1; i <= 8; i++) begin
            a = (3 + i) % 8;
            cyc(8'hFF, 1'b1, mk(0, 3'(prev), 8'h00, 0, 0));
            cyc(8'hFF, 1'b0, mk(1, 3'(a), oh_of(a), 0, 0));
            prev = a;
        end
        // Owner 3 drops its request; DONE while idle is ignored.
        cyc(8'h00, 1'b0, mk(0, 3, 8'h00, 0, 0));
        cyc(8'h00, 1'b1, mk(0, 3, 8'h00, 0, 0));

        // Watchdog: 16 grant cycles, one-cycle timeout pulse, re-grant to 7.
        cyc(8'h80, 1'b0, mk(1, 7, 8'h80, 0, 0));
        for (int i = 0; i < 15; i++)
            cyc(8'h80, 1'b0, mk(1, 7, 8'h80, 0, 0));
        cyc(8'h80, 1'b0, mk(0, 7, 8'h00, 1, 7));
        cyc(8'h80, 1'b0, mk(1, 7, 8'h80, 0, 7));
        cyc(8'h00, 1'b0, mk(0, 7, 8'h00, 0, 7));

        // DONE on the last allowed cycle beats the watchdog.
        cyc(8'h01, 1'b0, mk(1, 0, 8'h01, 0, 7));
        for (int i = 0; i < 15; i++)
            cyc(8'h01, 1'b0, mk(1, 0, 8'h01, 0, 7));
        cyc(8'h01, 1'b1, mk(0, 0, 8'h00, 0, 7));

        // Owner 5 aborts; non-owner request changes ignored; next grant to 0.
        cyc(8'h21, 1'b0, mk(1, 5, 8'h20, 0, 7));
        cyc(8'h27, 1'b0, mk(1, 5, 8'h20, 0, 7));
        cyc(8'h01, 1'b0, mk(0, 5, 8'h00, 0, 7));
        cyc(8'h01, 1'b0, mk(1, 0, 8'h01, 0, 7));
        cyc(8'h00, 1'b0, mk(0, 0, 8'h00, 0, 7));

        // Reset during a grant to 3, then REQ=09 grants 0.
        cyc(8'h08, 1'b0, mk(1, 3, 8'h08, 0, 7));
        #2;
        rst_n = 1'b0;
        req   = '0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(8'h09, 1'b0, mk(1, 0, 8'h01, 0, 0));
        cyc(8'h09, 1'b1, mk(0, 0, 8'h00, 0, 0));
        cyc(8'h08, 1'b0, mk(1, 3, 8'h08, 0, 0));

        // Second mid-grant reset; pointer must restart at 0, not 4.
        #2;
        rst_n = 1'b0;
        req   = '0;
        #1;
        check_zero("async_rst2");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(8'h11, 1'b0, mk(1, 0, 8'h01, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_bus_grant_encoder
